// File: rtl/osd_textbuf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : osd_textbuf_pkg
//  Purpose  : Shared definitions for the OSD text-buffer controller:
//             opcodes, default window geometry, control characters and
//             the controller state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package osd_textbuf_pkg;

   // Default window geometry (32 columns x 8 rows, 256-entry buffer)
   localparam int WINDOW_W_DEF = 32;
   localparam int WINDOW_H_DEF = 8;
   localparam int LOG2TXT_DEF  = 8;

   // Command opcodes
   localparam logic [2:0] OP_NOP     = 3'd0;
   localparam logic [2:0] OP_PUTC    = 3'd1;
   localparam logic [2:0] OP_GOTOX   = 3'd2;
   localparam logic [2:0] OP_GOTOY   = 3'd3;
   localparam logic [2:0] OP_CLEAR   = 3'd4;
   localparam logic [2:0] OP_SCROLL  = 3'd5;
   localparam logic [2:0] OP_SETATTR = 3'd6;
   localparam logic [2:0] OP_READ    = 3'd7;

   // Control characters interpreted by PUTC
   localparam logic [7:0] CHAR_LF = 8'h0A;
   localparam logic [7:0] CHAR_CR = 8'h0D;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_FILL  = 3'd2,
      ST_SRD   = 3'd3,
      ST_SWR   = 3'd4,
      ST_SFILL = 3'd5,
      ST_RA    = 3'd6,
      ST_RD    = 3'd7
   } state_t;

endpackage : osd_textbuf_pkg
`default_nettype wire

// File: rtl/osd_cursor.sv
`default_nettype none
// ============================================================================
//  Module   : osd_cursor
//  Purpose  : Registered text cursor (x,y) for the OSD controller.
//  Ports    : clk, reset_n        - clock, async active-low reset
//             set_x/x_val         - load column
//             set_y/y_val         - load row
//             advance             - step one column, wrapping to next row
//             newline             - column 0, next row
//             home                - move to (0,0)
//             cursor_x/cursor_y   - current cursor position
//             overflow            - this cycle's advance/newline ran off the
//                                   last row (row is held at the last row)
//  Revision : 1.0  initial release
// ============================================================================
module osd_cursor
   import osd_textbuf_pkg::*;
#(
   parameter int X_W = 5,
   parameter int Y_W = 3
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           set_x,
   input  logic [X_W-1:0] x_val,
   input  logic           set_y,
   input  logic [Y_W-1:0] y_val,
   input  logic           advance,
   input  logic           newline,
   input  logic           home,
   output logic [X_W-1:0] cursor_x,
   output logic [Y_W-1:0] cursor_y,
   output logic           overflow
);

   localparam logic [X_W-1:0] c_x_max = {X_W{1'b1}};
   localparam logic [Y_W-1:0] c_y_max = {Y_W{1'b1}};

   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;

   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      overflow = 1'b0;
      if (home) begin
         x_d = '0;
         y_d = '0;
      end else if (newline) begin
         x_d = '0;
         if (y_q == c_y_max) overflow = 1'b1;
         else                y_d      = y_q + 1'b1;
      end else if (advance) begin
         if (x_q == c_x_max) begin
            x_d = '0;
            if (y_q == c_y_max) overflow = 1'b1;
            else                y_d      = y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end else begin
         if (set_x) x_d = x_val;
         if (set_y) y_d = y_val;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign cursor_x = x_q;
   assign cursor_y = y_q;

endmodule : osd_cursor
`default_nettype wire

// File: rtl/osd_textbuf_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : osd_textbuf_ctl
//  Purpose  : Command-driven owner of port B of the OSD text buffer.
//             Executes PUTC / cursor moves / CLEAR / SCROLL / READ.
//  Ports    : clk, reset_n              - clock, async active-low reset
//             cmd_valid/cmd_ready       - command handshake
//             cmd_op, cmd_arg           - opcode and argument
//             busy                      - inverse of cmd_ready
//             cursor_x, cursor_y        - current cursor
//             rd_data, rd_valid         - READ result and its strobe
//             buf_address/data/wren     - port B write/read controls
//             buf_q                     - port B read data (1-cycle latency)
//  Revision : 1.0  initial release
// ============================================================================
module osd_textbuf_ctl
   import osd_textbuf_pkg::*;
#(
   parameter int         WINDOW_W  = WINDOW_W_DEF,
   parameter int         WINDOW_H  = WINDOW_H_DEF,
   parameter int         LOG2TXT   = LOG2TXT_DEF,
   parameter logic [7:0] FILL_CHAR = 8'h20
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [2:0]                  cmd_op,
   input  logic [7:0]                  cmd_arg,
   output logic                        busy,
   output logic [$clog2(WINDOW_W)-1:0] cursor_x,
   output logic [$clog2(WINDOW_H)-1:0] cursor_y,
   output logic [7:0]                  rd_data,
   output logic                        rd_valid,
   output logic [LOG2TXT-1:0]          buf_address,
   output logic [7:0]                  buf_data,
   output logic                        buf_wren,
   input  logic [7:0]                  buf_q
);

   localparam int X_W = $clog2(WINDOW_W);
   localparam int Y_W = $clog2(WINDOW_H);

   localparam logic [LOG2TXT-1:0] c_one         = LOG2TXT'(1);
   localparam logic [LOG2TXT-1:0] c_row_w       = LOG2TXT'(WINDOW_W);
   localparam logic [LOG2TXT-1:0] c_last_row    = LOG2TXT'(WINDOW_W * (WINDOW_H - 1));
   localparam logic [LOG2TXT-1:0] c_scroll_last = LOG2TXT'(WINDOW_W * (WINDOW_H - 1) - 1);
   localparam logic [LOG2TXT-1:0] c_addr_last   = LOG2TXT'(WINDOW_W * WINDOW_H - 1);

   state_t               state_q, state_d;
   logic [LOG2TXT-1:0]   addr_q, addr_d;
   logic                 attr_q, attr_d;
   logic [7:0]           rd_data_q, rd_data_d;
   logic                 rd_valid_q, rd_valid_d;
   logic [LOG2TXT-1:0]   buf_address_q, buf_address_d;
   logic [7:0]           buf_data_q, buf_data_d;
   logic                 buf_wren_q, buf_wren_d;

   logic                 w_accept;
   logic [LOG2TXT-1:0]   w_cursor_addr;

   logic                 cur_set_x, cur_set_y, cur_advance, cur_newline, cur_home;
   logic [X_W-1:0]       cur_x_val;
   logic [Y_W-1:0]       cur_y_val;
   logic                 cur_overflow;

   assign cmd_ready     = (state_q == ST_IDLE);
   assign busy          = ~cmd_ready;
   assign w_accept      = cmd_valid & cmd_ready;
   // Power-of-two geometry: row*W + col is just the concatenation
   assign w_cursor_addr = LOG2TXT'({cursor_y, cursor_x});

   osd_cursor #(
      .X_W (X_W),
      .Y_W (Y_W)
   ) u_cursor (
      .clk      (clk),
      .reset_n  (reset_n),
      .set_x    (cur_set_x),
      .x_val    (cur_x_val),
      .set_y    (cur_set_y),
      .y_val    (cur_y_val),
      .advance  (cur_advance),
      .newline  (cur_newline),
      .home     (cur_home),
      .cursor_x (cursor_x),
      .cursor_y (cursor_y),
      .overflow (cur_overflow)
   );

   // Cursor control is decoded separately from the next-state logic so that
   // the overflow flag returned by the cursor does not feed back into the
   // block that produced its inputs.
   always_comb begin
      cur_set_x   = 1'b0;
      cur_set_y   = 1'b0;
      cur_x_val   = cmd_arg[X_W-1:0];
      cur_y_val   = cmd_arg[Y_W-1:0];
      cur_advance = (state_q == ST_WRITE);
      cur_newline = 1'b0;
      cur_home    = (state_q == ST_FILL) && (addr_q == c_addr_last);
      if (w_accept) begin
         case (cmd_op)
            OP_GOTOX: cur_set_x = 1'b1;
            OP_GOTOY: cur_set_y = 1'b1;
            OP_PUTC: begin
               if (cmd_arg == CHAR_CR) begin
                  cur_set_x = 1'b1;
                  cur_x_val = '0;
               end else if (cmd_arg == CHAR_LF) begin
                  cur_newline = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      attr_d        = attr_q;
      rd_data_d     = rd_data_q;
      rd_valid_d    = 1'b0;
      buf_address_d = buf_address_q;
      buf_data_d    = buf_data_q;
      buf_wren_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               case (cmd_op)
                  OP_PUTC: begin
                     if (cmd_arg == CHAR_LF) begin
                        if (cur_overflow) begin
                           state_d       = ST_SRD;
                           addr_d        = '0;
                           buf_address_d = c_row_w;
                        end
                     end else if (cmd_arg != CHAR_CR) begin
                        state_d       = ST_WRITE;
                        buf_address_d = w_cursor_addr;
                        buf_data_d    = {cmd_arg[7] | attr_q, cmd_arg[6:0]};
                        buf_wren_d    = 1'b1;
                     end
                  end
                  OP_CLEAR: begin
                     state_d       = ST_FILL;
                     addr_d        = '0;
                     buf_address_d = '0;
                     buf_data_d    = cmd_arg;
                     buf_wren_d    = 1'b1;
                  end
                  OP_SCROLL: begin
                     state_d       = ST_SRD;
                     addr_d        = '0;
                     buf_address_d = c_row_w;
                  end
                  OP_SETATTR: attr_d = cmd_arg[7];
                  OP_READ: begin
                     state_d       = ST_RA;
                     buf_address_d = w_cursor_addr;
                  end
                  default: ;
               endcase
            end
         end

         ST_WRITE: begin
            // Advance happens this cycle; running off the last row scrolls
            if (cur_overflow) begin
               state_d       = ST_SRD;
               addr_d        = '0;
               buf_address_d = c_row_w;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_FILL: begin
            if (addr_q == c_addr_last) begin
               state_d = ST_IDLE;
            end else begin
               addr_d        = addr_q + c_one;
               buf_address_d = addr_q + c_one;
               buf_wren_d    = 1'b1;
            end
         end

         // Read a+W, then write it to a in the next cycle (data from buf_q)
         ST_SRD: begin
            state_d       = ST_SWR;
            buf_address_d = addr_q;
            buf_wren_d    = 1'b1;
         end

         ST_SWR: begin
            if (addr_q == c_scroll_last) begin
               state_d       = ST_SFILL;
               addr_d        = c_last_row;
               buf_address_d = c_last_row;
               buf_data_d    = FILL_CHAR;
               buf_wren_d    = 1'b1;
            end else begin
               state_d       = ST_SRD;
               addr_d        = addr_q + c_one;
               buf_address_d = addr_q + c_one + c_row_w;
            end
         end

         ST_SFILL: begin
            if (addr_q == c_addr_last) begin
               state_d = ST_IDLE;
            end else begin
               addr_d        = addr_q + c_one;
               buf_address_d = addr_q + c_one;
               buf_wren_d    = 1'b1;
            end
         end

         ST_RA: state_d = ST_RD;

         ST_RD: begin
            rd_data_d  = buf_q;
            rd_valid_d = 1'b1;
            state_d    = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         attr_q        <= 1'b0;
         rd_data_q     <= '0;
         rd_valid_q    <= 1'b0;
         buf_address_q <= '0;
         buf_data_q    <= '0;
         buf_wren_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         attr_q        <= attr_d;
         rd_data_q     <= rd_data_d;
         rd_valid_q    <= rd_valid_d;
         buf_address_q <= buf_address_d;
         buf_data_q    <= buf_data_d;
         buf_wren_q    <= buf_wren_d;
      end
   end

   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign buf_address = buf_address_q;
   assign buf_wren    = buf_wren_q;
   // Scroll copy passes the RAM output straight through in the write phase
   assign buf_data    = (state_q == ST_SWR) ? buf_q : buf_data_q;

endmodule : osd_textbuf_ctl
`default_nettype wire

// File: tb/tb_osd_textbuf_ctl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_osd_textbuf_ctl
//  Purpose  : Self-checking bench for osd_textbuf_ctl with a 256x8 RAM model
//             on port B and a screen-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_osd_textbuf_ctl;
   import osd_textbuf_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [2:0] cmd_op = 3'd0;
   logic [7:0] cmd_arg = 8'd0;
   logic       cmd_ready, busy, rd_valid, buf_wren;
   logic [4:0] cursor_x;
   logic [2:0] cursor_y;
   logic [7:0] rd_data, buf_address, buf_data;
   logic [7:0] buf_q;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   osd_textbuf_ctl dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_arg     (cmd_arg),
      .busy        (busy),
      .cursor_x    (cursor_x),
      .cursor_y    (cursor_y),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .buf_address (buf_address),
      .buf_data    (buf_data),
      .buf_wren    (buf_wren),
      .buf_q       (buf_q)
   );

   // ---------------- RAM on port B (registered address) ----------------
   logic [7:0] mem [256];
   logic       pre_en = 1'b0;
   logic [7:0] pre_addr = 8'd0;
   logic [7:0] pre_data = 8'd0;

   always @(posedge clk) begin
      if (pre_en)        mem[pre_addr]    <= pre_data;
      else if (buf_wren) mem[buf_address] <= buf_data;
      buf_q <= mem[buf_address];
   end

   // ---------------- monitors ----------------
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] wr_a [$];
   logic [7:0] wr_d [$];
   int         wr_c [$];
   int         rv_count = 0;
   int         rv_cyc = 0;
   logic [7:0] rv_data = 8'd0;

   always @(negedge clk) begin
      if (buf_wren === 1'b1) begin
         wr_a.push_back(buf_address);
         wr_d.push_back(buf_data);
         wr_c.push_back(cyc);
      end
      if (rd_valid === 1'b1) begin
         rv_count++;
         rv_cyc  = cyc;
         rv_data = rd_data;
      end
   end

   task automatic clear_log();
      wr_a.delete();
      wr_d.delete();
      wr_c.delete();
   endtask

   // ---------------- reference model (linear cursor position) ----------------
   int         m_pos = 0;
   logic       m_attr = 1'b0;
   logic [7:0] mm [256];
   logic [7:0] m_rd = 8'd0;

   function automatic void m_scroll();
      for (int a = 0; a < 224; a++) mm[a] = mm[a + 32];
      for (int a = 224; a < 256; a++) mm[a] = 8'h20;
   endfunction

   // Applies one command to the model; returns the expected busy cycles
   function automatic int m_apply(input logic [2:0] op, input logic [7:0] arg);
      int b;
      b = 0;
      case (op)
         3'd1: begin
            if (arg == 8'h0D) begin
               m_pos = (m_pos / 32) * 32;
            end else if (arg == 8'h0A) begin
               m_pos = (m_pos / 32 + 1) * 32;
               if (m_pos >= 256) begin m_pos -= 32; m_scroll(); b = 480; end
            end else begin
               mm[m_pos] = {arg[7] | m_attr, arg[6:0]};
               m_pos++;
               b = 1;
               if (m_pos >= 256) begin m_pos -= 32; m_scroll(); b = 481; end
            end
         end
         3'd2: m_pos = (m_pos / 32) * 32 + int'(arg[4:0]);
         3'd3: m_pos = int'(arg[2:0]) * 32 + (m_pos % 32);
         3'd4: begin
            for (int a = 0; a < 256; a++) mm[a] = arg;
            m_pos = 0;
            b = 256;
         end
         3'd5: begin m_scroll(); b = 480; end
         3'd6: m_attr = arg[7];
         3'd7: begin m_rd = mm[m_pos]; b = 2; end
         default: b = 0;
      endcase
      return b;
   endfunction

   // ---------------- stimulus drivers ----------------
   int acc = 0;   // cycle index right after the accept edge

   task automatic start_cmd(input logic [2:0] op, input logic [7:0] arg);
      int guard;
      guard = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 1000) begin
         vectors++; miscompares++;
         $display("FAIL start_cmd: cmd_ready=%b required 1 within 1000 cycles", cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      @(posedge clk);
      #1;
      acc       = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(output int busy_cycles);
      busy_cycles = 0;
      while (cmd_ready !== 1'b1 && busy_cycles < 2000) begin
         @(posedge clk);
         #1;
         busy_cycles++;
      end
      if (busy_cycles >= 2000) begin
         vectors++; miscompares++;
         $display("FAIL wait_idle: cmd_ready stuck low, %0d cycles", busy_cycles);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [7:0] arg, output int busy_cycles);
      start_cmd(op, arg);
      wait_idle(busy_cycles);
      @(negedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk);
      #1;
      pre_en = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int b;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({cmd_ready, busy, cursor_x, cursor_y, rd_valid, buf_wren} !== {1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_ctrl: got rdy=%b busy=%b x=%0d y=%0d rv=%b wren=%b, required 1 0 0 0 0 0",
                  cmd_ready, busy, cursor_x, cursor_y, rd_valid, buf_wren);
      end
      vectors++;
      if ({rd_data, buf_address, buf_data} !== 24'h0) begin
         miscompares++;
         $display("FAIL reset_data: got rd_data=%h addr=%h data=%h, required 00 00 00", rd_data, buf_address, buf_data);
      end
      @(negedge clk);
      reset_n = 1'b1;
      m_pos = 0; m_attr = 1'b0;

      // Reset in the middle of a CLEAR
      issue(OP_GOTOX, 8'd9, b); b = m_apply(OP_GOTOX, 8'd9);
      start_cmd(OP_CLEAR, 8'hAA);
      repeat (10) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (buf_wren !== 1'b1) begin
         miscompares++;
         $display("FAIL clear_active: buf_wren=%b required 1", buf_wren);
      end
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if (buf_wren !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_async_wren: buf_wren=%b required 0 before next edge", buf_wren);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      clear_log();
      reset_n = 1'b1;
      m_pos = 0; m_attr = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      vectors++;
      if (wr_a.size() != 0 || cmd_ready !== 1'b1 || cursor_x !== 5'd0 || cursor_y !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_release: writes=%0d rdy=%b x=%0d y=%0d, required 0 1 0 0",
                  wr_a.size(), cmd_ready, cursor_x, cursor_y);
      end
   endtask

   task automatic test_clear();
      int b, e, bad;
      issue(OP_GOTOX, 8'd7, b); e = m_apply(OP_GOTOX, 8'd7);
      issue(OP_GOTOY, 8'd3, b); e = m_apply(OP_GOTOY, 8'd3);
      clear_log();
      e = m_apply(OP_CLEAR, 8'h2A);
      issue(OP_CLEAR, 8'h2A, b);
      vectors++;
      if (b != 256 || b != e) begin
         miscompares++;
         $display("FAIL clear_busy: got %0d cycles, required 256", b);
      end
      bad = 0;
      if (wr_a.size() != 256) bad = 1;
      else for (int i = 0; i < 256; i++)
         if (wr_a[i] !== 8'(i) || wr_d[i] !== 8'h2A || wr_c[i] != acc + i) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL clear_writes: %0d writes, %0d out of order/wrong, required 256 of 2A to 0..255", wr_a.size(), bad);
      end
      vectors++;
      if ({cursor_y, cursor_x} !== 8'(m_pos) || m_pos != 0) begin
         miscompares++;
         $display("FAIL clear_cursor: got (%0d,%0d) required (0,0)", cursor_x, cursor_y);
      end
   endtask

   task automatic test_putc_attr();
      int b, e, zb;
      zb = 0;
      issue(OP_GOTOY, 8'd2, b);   e = m_apply(OP_GOTOY, 8'd2);   zb += b;
      issue(OP_GOTOX, 8'd31, b);  e = m_apply(OP_GOTOX, 8'd31);  zb += b;
      issue(OP_SETATTR, 8'h80, b); e = m_apply(OP_SETATTR, 8'h80); zb += b;
      vectors++;
      if (zb != 0) begin
         miscompares++;
         $display("FAIL zero_latency_ops: total busy %0d required 0", zb);
      end
      clear_log();
      e = m_apply(OP_PUTC, 8'h41);
      issue(OP_PUTC, 8'h41, b);
      vectors++;
      if (b != 1) begin
         miscompares++;
         $display("FAIL putc_busy: got %0d required 1", b);
      end
      vectors++;
      if (wr_a.size() != 1 || wr_a[0] !== 8'd95 || wr_d[0] !== 8'hC1 || wr_c[0] != acc) begin
         miscompares++;
         $display("FAIL putc_write: %0d writes, first addr=%0d data=%h, required 1 write of C1 to 95 in cycle after accept",
                  wr_a.size(), (wr_a.size() > 0) ? wr_a[0] : 8'hxx, (wr_d.size() > 0) ? wr_d[0] : 8'hxx);
      end
      vectors++;
      if (cursor_x !== 5'd0 || cursor_y !== 3'd3 || m_pos != 96) begin
         miscompares++;
         $display("FAIL putc_cursor: got (%0d,%0d) required (0,3)", cursor_x, cursor_y);
      end
      issue(OP_SETATTR, 8'h00, b); e = m_apply(OP_SETATTR, 8'h00);
   endtask

   task automatic test_read();
      int b, e, rv0;
      preload(8'd37, 8'h5B); mm[37] = 8'h5B;
      issue(OP_GOTOY, 8'd1, b); e = m_apply(OP_GOTOY, 8'd1);
      issue(OP_GOTOX, 8'd5, b); e = m_apply(OP_GOTOX, 8'd5);
      clear_log();
      rv0 = rv_count;
      e = m_apply(OP_READ, 8'h00);
      issue(OP_READ, 8'h00, b);
      vectors++;
      if (b != 2 || rv_count - rv0 != 1 || rv_cyc != acc + 2) begin
         miscompares++;
         $display("FAIL read_timing: busy=%0d pulses=%0d at +%0d, required busy 2, 1 pulse at +2",
                  b, rv_count - rv0, rv_cyc - acc);
      end
      vectors++;
      if (rv_data !== 8'h5B || m_rd !== 8'h5B) begin
         miscompares++;
         $display("FAIL read_data: got %h required 5B", rv_data);
      end
      vectors++;
      if (wr_a.size() != 0 || cursor_x !== 5'd5 || cursor_y !== 3'd1) begin
         miscompares++;
         $display("FAIL read_side: writes=%0d cursor=(%0d,%0d), required 0 writes, (5,1)", wr_a.size(), cursor_x, cursor_y);
      end
   endtask

   task automatic test_scroll();
      int b, e, bad;
      for (int n = 0; n < 256; n++) begin
         preload(8'(n), 8'(n));
         mm[n] = 8'(n);
      end
      issue(OP_GOTOY, 8'd7, b); e = m_apply(OP_GOTOY, 8'd7);
      issue(OP_GOTOX, 8'd5, b); e = m_apply(OP_GOTOX, 8'd5);
      clear_log();
      e = m_apply(OP_PUTC, 8'h0A);
      issue(OP_PUTC, 8'h0A, b);
      vectors++;
      if (b != 480 || e != 480) begin
         miscompares++;
         $display("FAIL scroll_busy: got %0d required 480", b);
      end
      vectors++;
      if (cursor_x !== 5'd0 || cursor_y !== 3'd7) begin
         miscompares++;
         $display("FAIL scroll_cursor: got (%0d,%0d) required (0,7)", cursor_x, cursor_y);
      end
      bad = 0;
      for (int a = 0; a < 256; a++) begin
         if (a < 224 && mem[a] !== 8'(a + 32)) bad++;
         if (a >= 224 && mem[a] !== 8'h20) bad++;
         if (mem[a] !== mm[a]) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL scroll_contents: %0d wrong bytes, required 0", bad);
      end
      bad = 0;
      if (wr_a.size() != 256) bad = 1;
      else for (int i = 0; i < 256; i++) if (wr_a[i] !== 8'(i)) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL scroll_order: %0d writes, %0d out of order, required 256 in order", wr_a.size(), bad);
      end
   endtask

   task automatic test_back_to_back();
      int b, e, not_ready;
      logic [2:0] ops [3];
      logic [7:0] args [3];
      ops[0] = OP_PUTC;  args[0] = 8'h0D;
      ops[1] = OP_GOTOX; args[1] = 8'd3;
      ops[2] = OP_GOTOY; args[2] = 8'd4;
      issue(OP_GOTOX, 8'd9, b); e = m_apply(OP_GOTOX, 8'd9);
      clear_log();
      not_ready = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (cmd_ready !== 1'b1) not_ready++;
         cmd_valid = 1'b1; cmd_op = ops[i]; cmd_arg = args[i];
         e = m_apply(ops[i], args[i]);
      end
      @(negedge clk);
      if (cmd_ready !== 1'b1) not_ready++;
      cmd_valid = 1'b0;
      vectors++;
      if (not_ready != 0 || wr_a.size() != 0) begin
         miscompares++;
         $display("FAIL b2b_handshake: %0d not-ready samples, %0d writes, required 0 and 0", not_ready, wr_a.size());
      end
      vectors++;
      if (cursor_x !== 5'd3 || cursor_y !== 3'd4 || {cursor_y, cursor_x} !== 8'(m_pos)) begin
         miscompares++;
         $display("FAIL b2b_cursor: got (%0d,%0d) required (3,4)", cursor_x, cursor_y);
      end
   endtask

   task automatic test_random();
      int b, e, rv0, ew, bad;
      logic [2:0] op;
      logic [7:0] arg;
      for (int it = 0; it < 80; it++) begin
         op  = 3'($urandom_range(0, 7));
         arg = 8'($urandom);
         if ((op == OP_CLEAR || op == OP_SCROLL) && $urandom_range(0, 3) != 0) op = OP_PUTC;
         if (op == OP_PUTC) begin
            case ($urandom_range(0, 5))
               0: arg = 8'h0A;
               1: arg = 8'h0D;
               default: ;
            endcase
         end
         clear_log();
         rv0 = rv_count;
         e = m_apply(op, arg);
         case (e)
            1:       ew = 1;
            256:     ew = 256;
            480:     ew = 256;
            481:     ew = 257;
            default: ew = 0;
         endcase
         issue(op, arg, b);
         vectors++;
         if (b != e || wr_a.size() != ew) begin
            miscompares++;
            $display("FAIL rand_busy op=%0d arg=%h: busy=%0d writes=%0d, required %0d and %0d",
                     op, arg, b, wr_a.size(), e, ew);
         end
         vectors++;
         if ({cursor_y, cursor_x} !== 8'(m_pos) || busy !== ~cmd_ready) begin
            miscompares++;
            $display("FAIL rand_cursor op=%0d arg=%h: got (%0d,%0d) busy=%b, required (%0d,%0d)",
                     op, arg, cursor_x, cursor_y, busy, m_pos % 32, m_pos / 32);
         end
         if (op == OP_READ) begin
            vectors++;
            if (rv_count - rv0 != 1 || rv_data !== m_rd) begin
               miscompares++;
               $display("FAIL rand_read: pulses=%0d data=%h, required 1 and %h", rv_count - rv0, rv_data, m_rd);
            end
         end
      end
      bad = 0;
      for (int a = 0; a < 256; a++) if (mem[a] !== mm[a]) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL rand_contents: %0d bytes differ from model, required 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_putc_attr();
      test_read();
      test_scroll();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_osd_textbuf_ctl
`default_nettype wire
